cache_refill_ctrl: RTL and testbench

//   Miss-handling controller for the direct-mapped read cache (tag 20b | index 10b | offset 2b).

---
 rtl/cache_refill_ctrl.sv | 117 +++++++++++
 tb/tb_cache_refill_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: read-miss controller for a direct-mapped cache with a req/ack refill path.
module cache_refill_ctrl #(
  parameter int DATAW   = 32,
  parameter int HIT_LAT = 3,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_req_i,
  input  logic [DATAW-1:0] cpu_addr_i,
  output logic             cpu_ready_o,
  output logic [DATAW-1:0] cpu_data_o,
  output logic             cpu_err_o,
  output logic             busy_o,
  output logic [DATAW-1:0] cache_addr_o,
  input  logic             hit_i,
  input  logic [DATAW-1:0] cache_data_i,
  output logic             cache_we_o,
  output logic [DATAW-1:0] cache_addw_o,
  output logic [DATAW-1:0] cache_dataw_o,
  output logic             mem_req_o,
  output logic [DATAW-1:0] mem_addr_o,
  input  logic             mem_ack_i,
  input  logic [DATAW-1:0] mem_data_i,
  output logic [CNTW-1:0]  hit_cnt_o,
  output logic [CNTW-1:0]  miss_cnt_o
);
  localparam int LW = $clog2(HIT_LAT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESP} state_t;
  state_t           state_q;
  logic [DATAW-1:0] addr_q, data_q;
  logic [LW-1:0]    lat_q;
  logic [TW-1:0]    to_q;
  logic [CNTW-1:0]  hit_q, miss_q;
  logic             rdy_q, err_q, we_q, mreq_q;
  // lat_q spans the cache pipeline so hit_i is sampled HIT_LAT+1 edges after acceptance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      lat_q   <= '0;
      to_q    <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      mreq_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req_i) begin
          addr_q  <= cpu_addr_i;
          lat_q   <= LW'(HIT_LAT);
          state_q <= LOOKUP;
        end
        LOOKUP: if (lat_q == '0) begin
          if (hit_i) begin
            data_q  <= cache_data_i;
            hit_q   <= (&hit_q) ? hit_q : hit_q + CNTW'(1);
            rdy_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            miss_q  <= (&miss_q) ? miss_q : miss_q + CNTW'(1);
            state_q <= MEM_REQ;
          end
        end else begin
          lat_q <= lat_q - LW'(1);
        end
        MEM_REQ: begin
          mreq_q  <= 1'b1;
          to_q    <= '0;
          state_q <= MEM_WAIT;
        end
        MEM_WAIT: if (mem_ack_i) begin
          data_q  <= mem_data_i;
          mreq_q  <= 1'b0;
          we_q    <= 1'b1;
          state_q <= FILL;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          data_q  <= '0;
          mreq_q  <= 1'b0;
          err_q   <= 1'b1;
          rdy_q   <= 1'b1;
          state_q <= RESP;
        end else begin
          to_q <= to_q + TW'(1);
        end
        FILL: begin
          we_q    <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          rdy_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cpu_ready_o   = rdy_q;
  assign cpu_data_o    = data_q;
  assign cpu_err_o     = err_q;
  assign busy_o        = state_q != IDLE;
  assign cache_addr_o  = addr_q;
  assign cache_we_o    = we_q;
  assign cache_addw_o  = addr_q;
  assign cache_dataw_o = data_q;
  assign mem_req_o     = mreq_q;
  assign mem_addr_o    = {addr_q[DATAW-1:2], 2'b00};
  assign hit_cnt_o     = hit_q;
  assign miss_cnt_o    = miss_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized bench with a transaction-timeline reference model.
module tb_cache_refill_ctrl;
  localparam int HL   = 3;
  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 1'b0, hit_in = 1'b0, mem_ack = 1'b0;
  logic [31:0] cpu_addr = '0, cache_data = '0, mem_data = '0;
  logic cpu_ready_o, cpu_err_o, busy_o, cache_we_o, mem_req_o;
  logic [31:0] cpu_data_o, cache_addr_o, cache_addw_o, cache_dataw_o, mem_addr_o;
  logic [CW-1:0] hit_cnt_o, miss_cnt_o;
  int vectors = 0, fails = 0;
  logic chk = 1'b0;
  logic e_busy, e_rdy, e_err, e_we, e_mreq;
  logic [31:0] e_data, e_dataw, m_addr;
  int m_hit, m_miss;
  int nreq, nwe, rc;
  logic got_err;
  logic [31:0] got_data, got_maddr;

  cache_refill_ctrl #(.DATAW(32), .HIT_LAT(HL), .TIMEOUT(TO), .CNTW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr),
    .cpu_ready_o(cpu_ready_o), .cpu_data_o(cpu_data_o), .cpu_err_o(cpu_err_o), .busy_o(busy_o),
    .cache_addr_o(cache_addr_o), .hit_i(hit_in), .cache_data_i(cache_data),
    .cache_we_o(cache_we_o), .cache_addw_o(cache_addw_o), .cache_dataw_o(cache_dataw_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk) begin
    check("busy", 32'(busy_o), 32'(e_busy));
    check("ready", 32'(cpu_ready_o), 32'(e_rdy));
    check("err", 32'(cpu_err_o), 32'(e_err));
    if (e_rdy) check("data", cpu_data_o, e_data);
    check("we", 32'(cache_we_o), 32'(e_we));
    if (e_we) begin
      check("dataw", cache_dataw_o, e_dataw);
      check("addw", cache_addw_o, m_addr);
    end
    check("mreq", 32'(mem_req_o), 32'(e_mreq));
    check("maddr", mem_addr_o, m_addr & ~32'd3);
    check("caddr", cache_addr_o, m_addr);
    check("hitcnt", 32'(hit_cnt_o), m_hit);
    check("misscnt", 32'(miss_cnt_o), m_miss);
  end

  task automatic rand_in();
    hit_in = 1'($urandom);
    cache_data = $urandom;
    mem_ack = 1'b0;
    mem_data = $urandom;
  endtask

  task automatic exp_idle();
    e_busy = 1'b0; e_rdy = 1'b0; e_err = 1'b0; e_we = 1'b0; e_mreq = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_addr = $urandom;
      rand_in(); exp_idle();
    end
  endtask

  // mode 0 = hit, 1 = miss acked after k wait cycles, 2 = miss never acked
  task automatic do_txn(input logic [31:0] a, input int mode, input int k,
                        input logic [31:0] hd, input logic [31:0] md);
    int r;
    r = (mode == 0) ? HL + 1 : (mode == 1) ? HL + k + 4 : HL + TO + 2;
    nreq = 0; nwe = 0; rc = -1; got_data = '0; got_err = 1'b0; got_maddr = '0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = a;
    rand_in(); exp_idle();
    for (int c = 0; c <= r; c++) begin
      @(posedge clk); #1;
      if (c == 0) m_addr = a;
      if (c == HL + 1) begin
        if (mode == 0) m_hit = (m_hit == CMAX) ? m_hit : m_hit + 1;
        else m_miss = (m_miss == CMAX) ? m_miss : m_miss + 1;
      end
      cpu_addr = $urandom;
      rand_in();
      if (c == HL) begin hit_in = (mode == 0); cache_data = hd; end
      if (mode == 1 && c == HL + 2 + k) begin mem_ack = 1'b1; mem_data = md; end
      e_busy = 1'b1;
      e_rdy = (c == r);
      e_err = (mode == 2) && (c == r);
      e_data = (mode == 0) ? hd : (mode == 1) ? md : 32'h0;
      e_mreq = (mode != 0) && c >= HL + 2 && c <= ((mode == 1) ? r - 2 : r - 1);
      e_we = (mode == 1) && (c == r - 1);
      e_dataw = md;
      if (cpu_ready_o) begin rc = c; got_data = cpu_data_o; got_err = cpu_err_o; end
      if (cache_we_o) nwe++;
      if (mem_req_o) begin nreq++; got_maddr = mem_addr_o; end
    end
  endtask

  task automatic reset_in_wait();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h0000_4440;
    rand_in(); exp_idle();
    for (int c = 0; c <= HL + 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) m_addr = 32'h0000_4440;
      if (c == HL + 1) m_miss = (m_miss == CMAX) ? m_miss : m_miss + 1;
      cpu_addr = $urandom;
      rand_in();
      if (c == HL) hit_in = 1'b0;
      e_busy = 1'b1; e_rdy = 1'b0; e_err = 1'b0; e_we = 1'b0;
      e_mreq = c >= HL + 2;
    end
    check("pre_rst_mreq", 32'(mem_req_o), 32'd1);
    chk = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_mreq", 32'(mem_req_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_hit", 32'(hit_cnt_o), 32'd0);
    check("rst_miss", 32'(miss_cnt_o), 32'd0);
    check("rst_we", 32'(cache_we_o), 32'd0);
    m_hit = 0; m_miss = 0; m_addr = '0;
    cpu_req = 1'b0;
    exp_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    chk = 1'b1;
    idle(6);
  endtask

  initial begin
    int mode;
    m_hit = 0; m_miss = 0; m_addr = '0;
    exp_idle(); e_data = '0; e_dataw = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(cpu_ready_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_mreq", 32'(mem_req_o), 32'd0);
    check("reset_caddr", cache_addr_o, 32'd0);
    check("reset_cnt", 32'({hit_cnt_o, miss_cnt_o}), 32'd0);
    rst = 1'b0;
    chk = 1'b1;
    idle(2);
    do_txn(32'h0000_1004, 0, 0, 32'hDEAD_BEEF, 32'h0);
    check("hit_latency", rc, HL + 1);
    check("hit_data", got_data, 32'hDEAD_BEEF);
    check("hit_no_mreq", nreq, 0);
    check("hit_cnt", 32'(hit_cnt_o), 32'd1);
    idle(1);
    do_txn(32'h0000_2008, 1, 4, 32'hFFFF_0000, 32'h1234_5678);
    check("miss_latency", rc, HL + 4 + 4);
    check("miss_maddr", got_maddr, 32'h0000_2008);
    check("miss_we_cycles", nwe, 1);
    check("miss_data", got_data, 32'h1234_5678);
    check("miss_cnt", 32'(miss_cnt_o), 32'd1);
    do_txn(32'h0005_5AA0, 2, 0, 32'h0, 32'h0);
    check("to_mreq_cycles", nreq, TO);
    check("to_err", 32'(got_err), 32'd1);
    check("to_data", got_data, 32'd0);
    check("to_no_we", nwe, 0);
    check("to_miss_cnt", 32'(miss_cnt_o), 32'd2);
    do_txn(32'h0000_700F, 1, TO - 1, 32'h0, 32'hCAFE_F00D);
    check("ack_at_to_err", 32'(got_err), 32'd0);
    check("ack_at_to_maddr", got_maddr, 32'h0000_700C);
    check("ack_at_to_data", got_data, 32'hCAFE_F00D);
    do_txn(32'h0000_3000, 1, 2, 32'h0, 32'h0BAD_F00D);
    check("busy_addr_maddr", got_maddr, 32'h0000_3000);
    check("busy_addr_caddr", cache_addr_o, 32'h0000_3000);
    reset_in_wait();
    for (int i = 0; i < 20; i++) do_txn($urandom, 0, 0, $urandom, 32'h0);
    check("sat_hit", 32'(hit_cnt_o), 32'hF);
    check("sat_miss", 32'(miss_cnt_o), 32'd0);
    for (int i = 0; i < 40; i++) begin
      mode = ($urandom_range(0, 9) < 4) ? 0 : ($urandom_range(0, 9) < 8) ? 1 : 2;
      do_txn($urandom, mode, $urandom_range(0, TO - 1), $urandom, $urandom);
      idle($urandom_range(0, 2));
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
